// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_PORTS    = 2;
    localparam int unsigned LOCK_MAX_DEF = 8;
    localparam int unsigned LOCK_CNT_W   = 8;
    localparam int unsigned STAT_W       = 16;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit increment counter with enable that sticks at all-ones.
module sat_counter16
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    output logic [STAT_W-1:0] o_cnt
);

    logic [STAT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + STAT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bus locking in front of the single-port dmem.
// Optional grant/conflict statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic              m0_lock,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m0_rdata,
    output logic [DW-1:0]     m1_rdata,
    output logic              mem_we,
    output logic [AW-1:0]     mem_a,
    output logic [DW-1:0]     mem_wd,
    input  logic [DW-1:0]     mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conf
`endif
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   r_last;
    logic                   w_last_nxt;
    logic [LOCK_CNT_W-1:0]  r_lock_cnt;
    logic [LOCK_CNT_W-1:0]  w_lock_cnt_nxt;
    logic [ARB_PORTS-1:0]   w_gnt;
    logic                   w_forced;
    logic                   w_lock_sel;
    logic                   w_lock_full;

    logic                   r_rvalid0;
    logic                   r_rvalid1;
    logic [DW-1:0]          r_rdata0;
    logic [DW-1:0]          r_rdata1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Grant selection and lock bookkeeping.
    always_comb begin
        w_gnt          = '0;
        w_forced       = 1'b0;
        w_lock_sel     = 1'b0;
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        w_lock_full    = (r_lock_cnt >= LOCK_CNT_W'(LOCK_MAX));

        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_gnt[0] = r_last;
                    w_gnt[1] = !r_last;
                end else begin
                    w_gnt[0] = m0_req;
                    w_gnt[1] = m1_req;
                end
            end
            OWN0: begin
                if (w_lock_full && m1_req) begin
                    w_gnt[1] = 1'b1;
                    w_forced = 1'b1;
                end else if (m0_req) begin
                    w_gnt[0] = 1'b1;
                end else begin
                    w_gnt[1] = m1_req;
                end
            end
            OWN1: begin
                if (w_lock_full && m0_req) begin
                    w_gnt[0] = 1'b1;
                    w_forced = 1'b1;
                end else if (m1_req) begin
                    w_gnt[1] = 1'b1;
                end else begin
                    w_gnt[0] = m0_req;
                end
            end
            default: ;
        endcase

        // Requests are ignored while reset is held.
        if (!reset) begin
            w_gnt = '0;
        end

        if (w_gnt != '0) begin
            w_last_nxt = w_gnt[1];
            w_lock_sel = w_gnt[1] ? m1_lock : m0_lock;
            if (w_forced || !w_lock_sel) begin
                w_state_nxt    = IDLE;
                w_lock_cnt_nxt = '0;
            end else if ((w_gnt[1] && (r_state == OWN1)) || (w_gnt[0] && (r_state == OWN0))) begin
                if (!w_lock_full) begin
                    w_lock_cnt_nxt = r_lock_cnt + LOCK_CNT_W'(1);
                end
            end else begin
                w_state_nxt    = w_gnt[1] ? OWN1 : OWN0;
                w_lock_cnt_nxt = LOCK_CNT_W'(1);
            end
        end
    end

    // Port 0 drives the memory bus whenever port 1 is not granted.
    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];
    assign mem_we = w_gnt[1] ? m1_we    : (w_gnt[0] & m0_we);
    assign mem_a  = w_gnt[1] ? m1_addr  : m0_addr;
    assign mem_wd = w_gnt[1] ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~m0_we;
            r_rvalid1 <= w_gnt[1] & ~m1_we;
            if (w_gnt[0] && !m0_we) begin
                r_rdata0 <= mem_rd;
            end
            if (w_gnt[1] && !m1_we) begin
                r_rdata1 <= mem_rd;
            end
        end
    end

    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

`ifdef DMEM_ARB_STATS_EN
    sat_counter16 u_stat_gnt0 (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_gnt[0]),
        .o_cnt (stat_gnt0)
    );

    sat_counter16 u_stat_gnt1 (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_gnt[1]),
        .o_cnt (stat_gnt1)
    );

    sat_counter16 u_stat_conf (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (m0_req & m1_req),
        .o_cnt (stat_conf)
    );
`else
    // Statistics-free build: no counters are instantiated.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then held random traffic
// against a rule-level reference model; stats checks when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    localparam int unsigned LOCK_MAX_T = 4;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_conf;
`endif

    logic [31:0] env_mem [0:63];
    logic [31:0] ref_mem [0:63];

    int total;
    int bad;

    // reference model state
    int          m_owner;
    int          m_last;
    int          m_cnt;
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    int          s_g0, s_g1, s_conf;

    assign mem_rd = env_mem[mem_a[7:2]];

    dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LOCK_MAX_T)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0 (stat_gnt0),
        .stat_gnt1 (stat_gnt1),
        .stat_conf (stat_conf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        s_g0    = 0;
        s_g1    = 0;
        s_conf  = 0;
    endtask

    // Who should win this cycle; g: 0 none, 1 port0, 2 port1.
    task automatic model_grant(output int g, output bit forced);
        int own_req, oth_req, oth;
        g = 0;
        forced = 1'b0;
        if (m_owner < 0) begin
            if (m0_req && m1_req) g = (m_last == 1) ? 1 : 2;
            else if (m0_req)      g = 1;
            else if (m1_req)      g = 2;
        end else begin
            oth     = 1 - m_owner;
            own_req = (m_owner == 0) ? int'(m0_req) : int'(m1_req);
            oth_req = (oth == 0) ? int'(m0_req) : int'(m1_req);
            if (oth_req != 0 && m_cnt >= int'(LOCK_MAX_T)) begin
                g = oth + 1;
                forced = 1'b1;
            end else if (own_req != 0) begin
                g = m_owner + 1;
            end else if (oth_req != 0) begin
                g = oth + 1;
            end
        end
    endtask

    task automatic model_update(input int g, input bit forced, input logic lk);
        int p;
        p = g - 1;
        if (forced || !lk) begin
            m_owner = -1;
            m_cnt   = 0;
        end else if (m_owner == p) begin
            if (m_cnt < int'(LOCK_MAX_T)) m_cnt++;
        end else begin
            m_owner = p;
            m_cnt   = 1;
        end
        m_last = p;
    endtask

    // Inputs are set before the call; checks the combinational grant, then the read return.
    task automatic cycle_check(output int g);
        bit          forced;
        logic        lk, d_we;
        logic [31:0] d_a, d_wd, e_a;
        #2;
        model_grant(g, forced);
        e_a = (g == 2) ? m1_addr : m0_addr;
        chk("gnt0", 32'(m0_gnt), 32'(g == 1));
        chk("gnt1", 32'(m1_gnt), 32'(g == 2));
        chk("mem_we", 32'(mem_we), 32'((g == 1 && m0_we) || (g == 2 && m1_we)));
        chk("mem_a", mem_a, e_a);
        if (g != 0) chk("mem_wd", mem_wd, (g == 2) ? m1_wdata : m0_wdata);
        d_we = mem_we;
        d_a  = mem_a;
        d_wd = mem_wd;
        exp_rv0 = (g == 1) && !m0_we;
        exp_rv1 = (g == 2) && !m1_we;
        if (exp_rv0) exp_rd0 = ref_mem[m0_addr[7:2]];
        if (exp_rv1) exp_rd1 = ref_mem[m1_addr[7:2]];
        if (g == 1 && m0_we) ref_mem[m0_addr[7:2]] = m0_wdata;
        if (g == 2 && m1_we) ref_mem[m1_addr[7:2]] = m1_wdata;
        if (m0_req && m1_req && s_conf < 65535) s_conf++;
        if (g == 1 && s_g0 < 65535) s_g0++;
        if (g == 2 && s_g1 < 65535) s_g1++;
        lk = (g == 2) ? m1_lock : m0_lock;
        if (g != 0) model_update(g, forced, lk);
        @(posedge clk);
        #1;
        if (d_we) env_mem[d_a[7:2]] = d_wd;
        chk("rvalid0", 32'(m0_rvalid), 32'(exp_rv0));
        chk("rvalid1", 32'(m1_rvalid), 32'(exp_rv1));
        chk("rdata0", m0_rdata, exp_rd0);
        chk("rdata1", m1_rdata, exp_rd1);
        @(negedge clk);
    endtask

    task automatic set_p0(input logic rq, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] wd);
        m0_req = rq; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = wd;
    endtask

    task automatic set_p1(input logic rq, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] wd);
        m1_req = rq; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    initial begin
        int g;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = env_mem[i];
        end
        env_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        model_reset();
        set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held with a pending request: nothing granted, all cleared.
        @(negedge clk);
        #2;
        chk("rst_gnt0", 32'(m0_gnt), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_rvalid0", 32'(m0_rvalid), 32'(0));
        chk("rst_rdata0", m0_rdata, 32'h0);
        reset = 1'b1;

        // First read after reset returns DEADBEEF one cycle later.
        cycle_check(g);
        chk("first_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Both ports reading every cycle without lock.
        for (int i = 0; i < 8; i++) begin
            set_p0(1'b1, 1'b0, 1'b0, rand_addr(), 32'h0);
            set_p1(1'b1, 1'b0, 1'b0, rand_addr(), 32'h0);
            cycle_check(g);
        end

        // Port 1 locked write burst while port 0 waits.
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle_check(g);
        set_p0(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
        set_p1(1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
        for (int i = 0; i < 3; i++) begin
            cycle_check(g);
            chk("lock_burst_g1", 32'(g), 32'(2));
        end
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle_check(g);
        chk("lock_burst_g0", 32'(g), 32'(1));

        // Continuous lock by port 1 is broken after LOCK_MAX grants.
        set_p0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        set_p1(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle_check(g);
            chk("forced_seq", 32'(g), (i == 4) ? 32'(1) : 32'(2));
        end

        // Reset asserted while port 1 owns the bus with a read returning.
        set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_p1(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        cycle_check(g);
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid1", 32'(m1_rvalid), 32'(0));
        chk("mid_rst_gnt1", 32'(m1_gnt), 32'(0));
        chk("mid_rst_rdata1", m1_rdata, 32'h0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'(0));
        model_reset();
        set_p0(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle_check(g);
        chk("post_rst_g0", 32'(g), 32'(1));

        // Random traffic; an ungranted request is held unchanged.
        for (int i = 0; i < 300; i++) begin
            if (!(m0_req && g != 1))
                set_p0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (!(m1_req && g != 2))
                set_p1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), rand_addr(), $urandom);
            cycle_check(g);
        end

`ifdef DMEM_ARB_STATS_EN
        chk("stat_gnt0", 32'(stat_gnt0), 32'(s_g0));
        chk("stat_gnt1", 32'(stat_gnt1), 32'(s_g1));
        chk("stat_conf", 32'(stat_conf), 32'(s_conf));
        force dut.u_stat_gnt0.r_cnt = 16'hFFFF;
        #1;
        release dut.u_stat_gnt0.r_cnt;
        set_p0(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle_check(g);
        cycle_check(g);
        chk("stat_sat", 32'(stat_gnt0), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`) between the `riscvsingle` core (port 0) and an external master such as a loader, debug or DMA engine (port 1). It sits between the requesters and `dmem` in `top`. It grants one access per cycle using round-robin priority with optional bus locking. It returns read data one cycle after the grant.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `LOCK_MAX`, default 8: maximum number of consecutive locked grants before a forced hand-off. The legal range is 1..255.

Ports:
- `clk` (in, 1): the single clock. All state changes on the rising edge.
- `reset` (in, 1): asynchronous, active-low reset. All state clears while `reset`=0.
- `m0_req`, `m1_req` (in, 1): access request, held until granted.
- `m0_we`, `m1_we` (in, 1): 1 = write, 0 = read.
- `m0_addr`, `m1_addr` (in, AW): byte address.
- `m0_wdata`, `m1_wdata` (in, DW): write data.
- `m0_lock`, `m1_lock` (in, 1): request to keep ownership after this grant.
- `m0_gnt`, `m1_gnt` (out, 1): access accepted this cycle.
- `m0_rvalid`, `m1_rvalid` (out, 1): read data valid. Pulses one cycle after a read grant.
- `m0_rdata`, `m1_rdata` (out, DW): registered read data.
- `mem_we` (out, 1): to `dmem` `we`.
- `mem_a` (out, AW): to `dmem` `a`.
- `mem_wd` (out, DW): to `dmem` `wd`.
- `mem_rd` (in, DW): from `dmem` `rd`, which is a combinational read.
- `stat_gnt0`, `stat_gnt1`, `stat_conf` (out, 16 each): exist only when `DMEM_ARB_STATS_EN` is defined.

## Operation
- The FSM has three states:
  - IDLE: no owner.
  - OWN0: port 0 is the locked owner.
  - OWN1: port 1 is the locked owner.
- `last` register: the port granted most recently. Reset value 1, so port 0 wins the first conflict.
- Arbitration in IDLE:
  - Exactly one request: that port is granted.
  - Both requesting: the port not equal to `last` is granted.
- Arbitration in OWNx:
  - The owner is granted whenever it requests.
  - The other port is granted only if the owner is not requesting.
- Lock handling:
  - A grant with `mx_lock`=1 moves the FSM to OWNx (or keeps it there) and increments `lock_cnt`.
  - A grant with `mx_lock`=0 returns the FSM to IDLE.
- Forced release: when `lock_cnt` reaches `LOCK_MAX` while the other port is requesting:
  - The next cycle grants the other port and sets the FSM to IDLE.
  - `lock_cnt` clears.
- `lock_cnt` clears on any ownership change and on entry to IDLE.
- Memory outputs:
  - `mem_we`, `mem_a` and `mem_wd` come combinationally from the granted port's signals.
  - `mem_we` = granted && `we`.
  - With no grant, `mem_we`=0 and `mem_a`/`mem_wd` hold the values of port 0.
- Read return: on a read grant, `mem_rd` is captured into that port's `rdata` register and that port's `rvalid` is set for the next cycle. Write grants produce no `rvalid`.
- `mx_rdata` holds its value until the next read completes on that port.
- At most one of `m0_gnt`/`m1_gnt` is high in any cycle.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from `req` and the registered state. It is never asserted without `req`.
- Read latency is 1 cycle: grant at edge N, `rvalid` and `rdata` valid during cycle N+1.
- Back-to-back grants to the same or alternating ports are allowed every cycle. Throughput is 1 access per cycle.
- Port 0 (the core) must stall while `m0_req`=1 and `m0_gnt`=0. This gating is external.
- Reset values:
  - FSM = IDLE, `last`=1, `lock_cnt`=0.
  - `m0_gnt`, `m1_gnt`, `m0_rvalid`, `m1_rvalid` and `mem_we` = 0, with `req` ignored during reset.
  - `m0_rdata`, `m1_rdata` = 0.
  - All stats counters = 0.
- Reset mid-lock: the lock is abandoned and arbitration restarts from IDLE. A pending `rvalid` is dropped.
- Requests are expected to stay stable until granted. A request withdrawn before grant is simply not served.

## Configuration
- Macro `DMEM_ARB_STATS_EN`.
- When defined, the block adds three 16-bit saturating counters:
  - `stat_gnt0`: grants to port 0.
  - `stat_gnt1`: grants to port 1.
  - `stat_conf`: cycles with both requests high.
- The counters stop at 0xFFFF and clear only on reset.
- When undefined, the stats ports and counters are absent and the remaining behaviour is identical.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - The state enum `arb_state_t` (IDLE, OWN0, OWN1).
  - Constant `ARB_PORTS=2`.
  - The default `LOCK_MAX`.
- One sub-module, `sat_counter16`: a saturating increment counter with enable. It is instantiated three times under the macro.
- The arbitration/FSM, output muxes and read-return registers stay in `dmem_arbiter`.

## Test plan
- Reset release with `m0_req`=1 read at 0x10, mem holding 0xDEADBEEF → `m0_gnt`=1 in cycle 0, then `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF in cycle 1.
- Both ports request reads every cycle with no lock → grants alternate 0,1,0,1. Each `rvalid` lands on the matching port one cycle later.
- Port 1 writes 0x55 to 0x20 with lock=1 for 3 cycles while port 0 requests → `m1_gnt` for 3 cycles, `mem_we`=1 and `mem_a`=0x20 each cycle, `m0_gnt` in the 4th cycle.
- `LOCK_MAX`=4, port 1 locks continuously while port 0 requests → after 4 `m1` grants, `m0` is granted in cycle 5 and the FSM is in IDLE.
- Assert `reset`=0 during OWN1 with a read in flight → all outputs go to 0 asynchronously. After release, a port 0 request is granted first.
- With `DMEM_ARB_STATS_EN`: 10 conflict cycles → `stat_conf`=10 and `stat_gnt0`+`stat_gnt1`=10. Forcing a counter to 0xFFFF → it stays at 0xFFFF on further grants.
